// File: rtl/execute_stage.sv
// Execute stage of a five-stage Y86-64 style pipeline: operand select, ALU, condition codes,
// branch/cmov condition and the E->M pipeline register. Option macro: EXE_CC_EXC_GATE_EN.
module execute_stage #(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              M_bubble,
  input  logic [2:0]        E_stat,
  input  logic [3:0]        E_icode,
  input  logic [3:0]        E_ifun,
  input  logic [WORD_W-1:0] E_valA,
  input  logic [WORD_W-1:0] E_valB,
  input  logic [WORD_W-1:0] E_valC,
  input  logic [3:0]        E_dstE,
  input  logic [3:0]        E_dstM,
  input  logic [2:0]        m_stat,
  input  logic [2:0]        W_stat,
  output logic [WORD_W-1:0] e_valE,
  output logic [3:0]        e_dstE,
  output logic              e_Cnd,
  output logic [2:0]        cc,
  output logic [2:0]        M_stat,
  output logic [3:0]        M_icode,
  output logic              M_Cnd,
  output logic [WORD_W-1:0] M_valE,
  output logic [WORD_W-1:0] M_valA,
  output logic [3:0]        M_dstE,
  output logic [3:0]        M_dstM
);

  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [WORD_W-1:0] K_POS8 = WORD_W'(8);
  localparam logic [WORD_W-1:0] K_NEG8 = {{(WORD_W-4){1'b1}}, 4'b1000};

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic              cnd;
    logic [WORD_W-1:0] val_e;
    logic [WORD_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } m_reg_t;

  localparam cc_t    CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};
  localparam m_reg_t M_BUBBLE = '{
    stat:  SAOK,
    icode: I_NOP,
    cnd:   1'b0,
    val_e: '0,
    val_a: '0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  logic [WORD_W-1:0] w_alu_a;
  logic [WORD_W-1:0] w_alu_b;
  logic [3:0]        w_alu_fn;
  logic [WORD_W-1:0] w_alu_res;
  logic              w_alu_of;
  cc_t               w_new_cc;
  logic              w_set_cc;
  logic              w_cnd;
  logic [3:0]        w_dst_e;
  m_reg_t            w_m_next;

  cc_t               r_cc;
  m_reg_t            r_m;

  // NOTE: every always_comb output gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              w_alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = E_valC;
      I_CALL, I_PUSHQ:              w_alu_a = K_NEG8;
      I_RET, I_POPQ:                w_alu_a = K_POS8;
      default:                      w_alu_a = '0;
    endcase
  end

  always_comb begin
    w_alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = E_valB;
      default:                                                   w_alu_b = '0;
    endcase
  end

  assign w_alu_fn = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  // Overflow is a sign check on the operands as seen by the ALU (B op A).
  always_comb begin
    w_alu_res = '0;
    w_alu_of  = 1'b0;
    case (w_alu_fn)
      ALU_ADD: begin
        w_alu_res = w_alu_b + w_alu_a;
        w_alu_of  = (w_alu_a[WORD_W-1] == w_alu_b[WORD_W-1]) &&
                    (w_alu_res[WORD_W-1] != w_alu_b[WORD_W-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_alu_b - w_alu_a;
        w_alu_of  = (w_alu_a[WORD_W-1] != w_alu_b[WORD_W-1]) &&
                    (w_alu_res[WORD_W-1] != w_alu_b[WORD_W-1]);
      end
      ALU_AND: w_alu_res = w_alu_b & w_alu_a;
      ALU_XOR: w_alu_res = w_alu_b ^ w_alu_a;
      default: begin
        w_alu_res = '0;
        w_alu_of  = 1'b0;
      end
    endcase
  end

  assign w_new_cc = '{
    zf: (w_alu_res == '0),
    sf: w_alu_res[WORD_W-1],
    of: w_alu_of
  };

`ifdef EXE_CC_EXC_GATE_EN
  logic w_down_exc;
  // A faulting instruction further down the pipe must not see its successors change cc.
  assign w_down_exc = (m_stat == SHLT) || (m_stat == SADR) || (m_stat == SINS) ||
                      (W_stat == SHLT) || (W_stat == SADR) || (W_stat == SINS);
  assign w_set_cc   = (E_icode == I_OPQ) && !w_down_exc;
`else
  logic w_unused_stat;
  assign w_unused_stat = ^{m_stat, W_stat};
  assign w_set_cc      = (E_icode == I_OPQ);
`endif

  // Condition is taken from the flags already in cc, not the ones this OPq produces.
  always_comb begin
    w_cnd = 1'b0;
    case (E_ifun)
      C_ALWAYS: w_cnd = 1'b1;
      C_LE:     w_cnd = (r_cc.sf ^ r_cc.of) | r_cc.zf;
      C_L:      w_cnd = r_cc.sf ^ r_cc.of;
      C_E:      w_cnd = r_cc.zf;
      C_NE:     w_cnd = !r_cc.zf;
      C_GE:     w_cnd = !(r_cc.sf ^ r_cc.of);
      C_G:      w_cnd = !(r_cc.sf ^ r_cc.of) && !r_cc.zf;
      default:  w_cnd = 1'b0;
    endcase
  end

  assign w_dst_e = ((E_icode == I_RRMOVQ) && !w_cnd) ? RNONE : E_dstE;

  assign e_valE = w_alu_res;
  assign e_dstE = w_dst_e;
  assign e_Cnd  = w_cnd;

  always_comb begin
    w_m_next = M_BUBBLE;
    if (!M_bubble) begin
      w_m_next = '{
        stat:  E_stat,
        icode: E_icode,
        cnd:   w_cnd,
        val_e: w_alu_res,
        val_a: E_valA,
        dst_e: w_dst_e,
        dst_m: E_dstM
      };
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_set_cc) begin
      r_cc <= w_new_cc;
    end
  end

  // NOTE: the whole M register is reset, since a bubble must be visible
  // downstream the moment reset asserts, not after the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= M_BUBBLE;
    end else begin
      r_m <= w_m_next;
    end
  end

  assign cc      = r_cc;
  assign M_stat  = r_m.stat;
  assign M_icode = r_m.icode;
  assign M_Cnd   = r_m.cnd;
  assign M_valE  = r_m.val_e;
  assign M_valA  = r_m.val_a;
  assign M_dstE  = r_m.dst_e;
  assign M_dstM  = r_m.dst_m;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; drives at negedge, checks combinational
// outputs before the rising edge and registered outputs 1 ns after it.
module tb_execute_stage;

  localparam int WORD_W = 64;

  logic              clk;
  logic              rst_n;
  logic              M_bubble;
  logic [2:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [WORD_W-1:0] E_valA;
  logic [WORD_W-1:0] E_valB;
  logic [WORD_W-1:0] E_valC;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;
  logic [2:0]        m_stat;
  logic [2:0]        W_stat;
  logic [WORD_W-1:0] e_valE;
  logic [3:0]        e_dstE;
  logic              e_Cnd;
  logic [2:0]        cc;
  logic [2:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [WORD_W-1:0] M_valE;
  logic [WORD_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;

  int n_checks;
  int n_errors;

  execute_stage #(.WORD_W(WORD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .M_bubble (M_bubble),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_valC   (E_valC),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .e_valE   (e_valE),
    .e_dstE   (e_dstE),
    .e_Cnd    (e_Cnd),
    .cc       (cc),
    .M_stat   (M_stat),
    .M_icode  (M_icode),
    .M_Cnd    (M_Cnd),
    .M_valE   (M_valE),
    .M_valA   (M_valA),
    .M_dstE   (M_dstE),
    .M_dstM   (M_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    M_bubble = 1'b0;
    E_stat   = 3'd1;
    E_icode  = 4'h1;
    E_ifun   = 4'h0;
    E_valA   = '0;
    E_valB   = '0;
    E_valC   = '0;
    E_dstE   = 4'hF;
    E_dstM   = 4'hF;
    m_stat   = 3'd1;
    W_stat   = 3'd1;
  endtask

  task automatic drive_op(input logic [3:0] ifun, input logic [63:0] a, input logic [63:0] b);
    drive_nop();
    E_icode = 4'h6;
    E_ifun  = ifun;
    E_valA  = a;
    E_valB  = b;
    E_dstE  = 4'h2;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_nop();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (M_icode !== 4'h1) begin n_errors++; $display("FAIL reset_M_icode: got %h expected 1", M_icode); end
    n_checks++; if (M_dstE !== 4'hF) begin n_errors++; $display("FAIL reset_M_dstE: got %h expected f", M_dstE); end
    n_checks++; if (M_dstM !== 4'hF) begin n_errors++; $display("FAIL reset_M_dstM: got %h expected f", M_dstM); end
    n_checks++; if (M_stat !== 3'd1) begin n_errors++; $display("FAIL reset_M_stat: got %0d expected 1", M_stat); end
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL reset_cc: got %b expected 100", cc); end
    n_checks++; if (M_valE !== 64'h0) begin n_errors++; $display("FAIL reset_M_valE: got %h expected 0", M_valE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_opq_sub();
    @(negedge clk);
    drive_op(4'h1, 64'd5, 64'd5);
    E_dstM = 4'h7;
    #1;
    n_checks++; if (e_valE !== 64'h0) begin n_errors++; $display("FAIL sub_e_valE: got %h expected 0", e_valE); end
    edge_sample();
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL sub_cc: got %b expected 100", cc); end
    n_checks++; if (M_valE !== 64'h0) begin n_errors++; $display("FAIL sub_M_valE: got %h expected 0", M_valE); end
    n_checks++; if (M_icode !== 4'h6) begin n_errors++; $display("FAIL sub_M_icode: got %h expected 6", M_icode); end
    n_checks++; if (M_valA !== 64'd5) begin n_errors++; $display("FAIL sub_M_valA: got %h expected 5", M_valA); end
    n_checks++; if (M_dstM !== 4'h7) begin n_errors++; $display("FAIL sub_M_dstM: got %h expected 7", M_dstM); end
    // 3 - 5 = -2: negative, no overflow
    @(negedge clk);
    drive_op(4'h1, 64'd5, 64'd3);
    #1;
    n_checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_errors++; $display("FAIL sub_neg_e_valE: got %h expected fffffffffffffffe", e_valE); end
    edge_sample();
    n_checks++; if (cc !== 3'b010) begin n_errors++; $display("FAIL sub_neg_cc: got %b expected 010", cc); end
    // 0x8000.. - 1 overflows
    @(negedge clk);
    drive_op(4'h1, 64'd1, 64'h8000_0000_0000_0000);
    #1;
    n_checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL sub_ovf_e_valE: got %h expected 7fffffffffffffff", e_valE); end
    edge_sample();
    n_checks++; if (cc !== 3'b001) begin n_errors++; $display("FAIL sub_ovf_cc: got %b expected 001", cc); end
  endtask

  task automatic test_add_overflow();
    @(negedge clk);
    drive_op(4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    #1;
    n_checks++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_errors++; $display("FAIL add_ovf_e_valE: got %h expected fffffffffffffffe", e_valE); end
    n_checks++; if (cc !== 3'b001) begin n_errors++; $display("FAIL add_ovf_cc_before_edge: got %b expected 001", cc); end
    edge_sample();
    n_checks++; if (cc !== 3'b011) begin n_errors++; $display("FAIL add_ovf_cc: got %b expected 011", cc); end
  endtask

  task automatic test_cmov();
    @(negedge clk);
    drive_op(4'h0, 64'd1, 64'd1);
    edge_sample();
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL cmov_setup_cc: got %b expected 000", cc); end
    @(negedge clk);
    drive_nop();
    E_icode = 4'h2;
    E_ifun  = 4'h1;
    E_valA  = 64'h1234;
    E_dstE  = 4'h3;
    #1;
    n_checks++; if (e_Cnd !== 1'b0) begin n_errors++; $display("FAIL cmovle_e_Cnd: got %b expected 0", e_Cnd); end
    n_checks++; if (e_dstE !== 4'hF) begin n_errors++; $display("FAIL cmovle_e_dstE: got %h expected f", e_dstE); end
    n_checks++; if (e_valE !== 64'h1234) begin n_errors++; $display("FAIL cmovle_e_valE: got %h expected 1234", e_valE); end
    edge_sample();
    n_checks++; if (M_dstE !== 4'hF) begin n_errors++; $display("FAIL cmovle_M_dstE: got %h expected f", M_dstE); end
    n_checks++; if (M_Cnd !== 1'b0) begin n_errors++; $display("FAIL cmovle_M_Cnd: got %b expected 0", M_Cnd); end
    // cmovne with ZF=0 is taken
    @(negedge clk);
    E_ifun = 4'h4;
    #1;
    n_checks++; if (e_Cnd !== 1'b1) begin n_errors++; $display("FAIL cmovne_e_Cnd: got %b expected 1", e_Cnd); end
    n_checks++; if (e_dstE !== 4'h3) begin n_errors++; $display("FAIL cmovne_e_dstE: got %h expected 3", e_dstE); end
    edge_sample();
    n_checks++; if (M_dstE !== 4'h3) begin n_errors++; $display("FAIL cmovne_M_dstE: got %h expected 3", M_dstE); end
    n_checks++; if (M_Cnd !== 1'b1) begin n_errors++; $display("FAIL cmovne_M_Cnd: got %b expected 1", M_Cnd); end
    // ifun 9 is not a valid condition
    @(negedge clk);
    E_ifun = 4'h9;
    #1;
    n_checks++; if (e_Cnd !== 1'b0) begin n_errors++; $display("FAIL cond_ifun9_e_Cnd: got %b expected 0", e_Cnd); end
    // rrmovq always moves
    E_ifun = 4'h0;
    #1;
    n_checks++; if (e_dstE !== 4'h3) begin n_errors++; $display("FAIL rrmovq_e_dstE: got %h expected 3", e_dstE); end
  endtask

  task automatic test_stack_ops();
    @(negedge clk);
    drive_nop();
    E_icode = 4'hA;
    E_valB  = 64'h100;
    E_valA  = 64'hDEAD;
    #1;
    n_checks++; if (e_valE !== 64'hF8) begin n_errors++; $display("FAIL push_e_valE: got %h expected f8", e_valE); end
    edge_sample();
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL push_cc_held: got %b expected 000", cc); end
    n_checks++; if (M_valE !== 64'hF8) begin n_errors++; $display("FAIL push_M_valE: got %h expected f8", M_valE); end
    @(negedge clk);
    E_icode = 4'hB;
    #1;
    n_checks++; if (e_valE !== 64'h108) begin n_errors++; $display("FAIL pop_e_valE: got %h expected 108", e_valE); end
    E_icode = 4'h5;
    E_valC  = 64'h20;
    #1;
    n_checks++; if (e_valE !== 64'h120) begin n_errors++; $display("FAIL mrmovq_e_valE: got %h expected 120", e_valE); end
    E_icode = 4'h3;
    #1;
    n_checks++; if (e_valE !== 64'h20) begin n_errors++; $display("FAIL irmovq_e_valE: got %h expected 20", e_valE); end
  endtask

  task automatic test_exc_gate();
    @(negedge clk);
    drive_op(4'h1, 64'd7, 64'd7);
    m_stat = 3'd3;
    edge_sample();
`ifdef EXE_CC_EXC_GATE_EN
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL gate_m_stat_cc: got %b expected 000", cc); end
    @(negedge clk);
    m_stat = 3'd1;
    W_stat = 3'd4;
    edge_sample();
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL gate_W_stat_cc: got %b expected 000", cc); end
    @(negedge clk);
    W_stat = 3'd1;
    edge_sample();
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL gate_clear_cc: got %b expected 100", cc); end
`else
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL nogate_cc: got %b expected 100", cc); end
`endif
  endtask

  task automatic test_bubble();
    @(negedge clk);
    drive_op(4'h0, 64'd1, 64'd1);
    edge_sample();
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL bubble_setup_cc: got %b expected 000", cc); end
    @(negedge clk);
    drive_op(4'h1, 64'd1, 64'd1);
    M_bubble = 1'b1;
    E_dstM   = 4'h5;
    E_stat   = 3'd2;
    edge_sample();
    n_checks++; if (M_icode !== 4'h1) begin n_errors++; $display("FAIL bubble_M_icode: got %h expected 1", M_icode); end
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL bubble_cc: got %b expected 100", cc); end
    n_checks++; if (M_stat !== 3'd1) begin n_errors++; $display("FAIL bubble_M_stat: got %0d expected 1", M_stat); end
    n_checks++; if (M_valA !== 64'h0) begin n_errors++; $display("FAIL bubble_M_valA: got %h expected 0", M_valA); end
    n_checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin n_errors++; $display("FAIL bubble_M_dst: got %h/%h expected f/f", M_dstE, M_dstM); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_op(4'h2, 64'hF0, 64'h3C);
    #1;
    n_checks++; if (e_valE !== 64'h30) begin n_errors++; $display("FAIL and_e_valE: got %h expected 30", e_valE); end
    edge_sample();
    n_checks++; if (M_valE !== 64'h30) begin n_errors++; $display("FAIL and_M_valE: got %h expected 30", M_valE); end
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL and_cc: got %b expected 000", cc); end
    @(negedge clk);
    drive_op(4'h3, 64'h8000_0000_0000_00F0, 64'h3C);
    E_stat = 3'd3;
    #1;
    n_checks++; if (M_valE !== 64'h30) begin n_errors++; $display("FAIL xor_M_valE_before_edge: got %h expected 30", M_valE); end
    edge_sample();
    n_checks++; if (M_valE !== 64'h8000_0000_0000_00CC) begin n_errors++; $display("FAIL xor_M_valE: got %h expected 80000000000000cc", M_valE); end
    n_checks++; if (cc !== 3'b010) begin n_errors++; $display("FAIL xor_cc: got %b expected 010", cc); end
    n_checks++; if (M_stat !== 3'd3) begin n_errors++; $display("FAIL xor_M_stat: got %0d expected 3", M_stat); end
    @(negedge clk);
    drive_op(4'h7, 64'h5, 64'h9);
    #1;
    n_checks++; if (e_valE !== 64'h0) begin n_errors++; $display("FAIL badfn_e_valE: got %h expected 0", e_valE); end
    edge_sample();
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL badfn_cc: got %b expected 100", cc); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    drive_op(4'h0, 64'd1, 64'd2);
    edge_sample();
    n_checks++; if (M_valE !== 64'd3) begin n_errors++; $display("FAIL midrst_pre_M_valE: got %h expected 3", M_valE); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (M_icode !== 4'h1 || M_valE !== 64'h0) begin n_errors++; $display("FAIL midrst_M: got icode %h valE %h expected 1/0", M_icode, M_valE); end
    n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL midrst_cc: got %b expected 100", cc); end
    edge_sample();
    n_checks++; if (M_icode !== 4'h1) begin n_errors++; $display("FAIL midrst_held_M_icode: got %h expected 1", M_icode); end
    @(negedge clk);
    rst_n = 1'b1;
    edge_sample();
    n_checks++; if (M_icode !== 4'h6 || M_valE !== 64'd3) begin n_errors++; $display("FAIL midrst_resume_M: got icode %h valE %h expected 6/3", M_icode, M_valE); end
    n_checks++; if (cc !== 3'b000) begin n_errors++; $display("FAIL midrst_resume_cc: got %b expected 000", cc); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_opq_sub();
    test_add_overflow();
    test_cmov();
    test_stack_ops();
    test_exc_gate();
    test_bubble();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
